// File: rtl/matrix_kxk_win_pkg.sv
// Shared ISP definitions: border encodings and the pixel/line counter type.
package matrix_kxk_win_pkg;

    localparam int BORDER_REPL = 0;
    localparam int BORDER_ZERO = 1;

    localparam int CNT_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/matrix_kxk_win_line_buf.sv
// One image line of storage: simple dual-port RAM with a registered read port.
module line_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 480,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port: contents are never cleared, stale data is masked upstream.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: one cycle of latency, holds its last value when not reading.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/matrix_kxk_win.sv
// KxK sliding window generator over a raster pixel stream, with edge handling.
// Stage 0 accepts the pixel and reads the line buffers, stage 1 writes the
// cascade and resolves borders, and the window registers follow.
module matrix_kxk_win
    import matrix_kxk_win_pkg::*;
#(
    parameter int DW     = 8,
    parameter int K      = 3,
    parameter int H_DISP = 480,
    parameter int V_DISP = 272,
    parameter int BORDER = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic              din_sof,
    input  logic [DW-1:0]     din,
    output logic [K*K*DW-1:0] win,
    output logic              win_vld,
    output logic              win_sof,
    output logic              win_eol
);

    localparam int   AW        = $clog2(H_DISP);
    localparam int   NB        = K - 1;
    localparam bit   ZERO_FILL = (BORDER == BORDER_ZERO);
    localparam cnt_t COL_LAST  = cnt_t'(H_DISP - 1);
    localparam cnt_t ROW_LAST  = cnt_t'(V_DISP - 1);

    cnt_t          r_col;
    cnt_t          r_row;
    cnt_t          w_col;
    cnt_t          w_row;
    cnt_t          w_col_nxt;
    cnt_t          w_row_nxt;

    logic          r_vld1;
    logic [DW-1:0] r_din1;
    cnt_t          r_col1;
    cnt_t          r_row1;

    logic [DW-1:0] w_lb_wdata [NB];
    logic [DW-1:0] w_lb_rdata [NB];
    logic [DW-1:0] w_vcol     [K];

    logic [DW-1:0] r_win [K][K];
    logic          r_win_vld;
    logic          r_win_sof;
    logic          r_win_eol;

    // Position of the incoming pixel (sof forces 0,0) and where counting goes next.
    always_comb begin
        w_col     = din_sof ? '0 : r_col;
        w_row     = din_sof ? '0 : r_row;
        w_col_nxt = w_col + cnt_t'(1);
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + cnt_t'(1);
        end
    end

    // Raster counters advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (din_vld) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Stage 1 register: pixel and its position, aligned with line buffer read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1 <= 1'b0;
            r_din1 <= '0;
            r_col1 <= '0;
            r_row1 <= '0;
        end else begin
            r_vld1 <= din_vld;
            if (din_vld) begin
                r_din1 <= din;
                r_col1 <= w_col;
                r_row1 <= w_row;
            end
        end
    end

    // Cascade: buffer 0 takes the new pixel, each later buffer takes the line
    // its predecessor just gave up, written back at the address it was read from.
    for (genvar n = 0; n < NB; n++) begin : g_lb
        if (n == 0) begin : g_head
            assign w_lb_wdata[n] = r_din1;
        end else begin : g_tail
            assign w_lb_wdata[n] = w_lb_rdata[n-1];
        end

        line_buf #(
            .DW    (DW),
            .DEPTH (H_DISP),
            .AW    (AW)
        ) u_line_buf (
            .clk       (clk),
            .i_wr_en   (r_vld1),
            .i_wr_addr (r_col1[AW-1:0]),
            .i_wr_data (w_lb_wdata[n]),
            .i_rd_en   (din_vld),
            .i_rd_addr (w_col[AW-1:0]),
            .o_rd_data (w_lb_rdata[n])
        );
    end

    // Vertical slice for the new column; rows above the frame top copy the row below or zero.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_vcol[j] = '0;
        end
        w_vcol[K-1] = r_din1;
        for (int j = K - 2; j >= 0; j--) begin
            if (r_row1 >= cnt_t'(K - 1 - j)) begin
                w_vcol[j] = w_lb_rdata[K-2-j];
            end else if (ZERO_FILL) begin
                w_vcol[j] = '0;
            end else begin
                w_vcol[j] = w_vcol[j+1];
            end
        end
    end

    // Column shift registers: column 0 preloads the left border, later columns shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < K; j++) begin
                for (int i = 0; i < K; i++) begin
                    r_win[j][i] <= '0;
                end
            end
            r_win_vld <= 1'b0;
            r_win_sof <= 1'b0;
            r_win_eol <= 1'b0;
        end else begin
            r_win_vld <= r_vld1;
            r_win_sof <= r_vld1 && (r_row1 == '0) && (r_col1 == '0);
            r_win_eol <= r_vld1 && (r_col1 == COL_LAST);
            if (r_vld1) begin
                for (int j = 0; j < K; j++) begin
                    for (int i = 0; i < K - 1; i++) begin
                        if (r_col1 == '0) begin
                            r_win[j][i] <= ZERO_FILL ? '0 : w_vcol[j];
                        end else begin
                            r_win[j][i] <= r_win[j][i+1];
                        end
                    end
                    r_win[j][K-1] <= w_vcol[j];
                end
            end
        end
    end

    // Flatten the window, oldest row and leftmost column at the low end.
    always_comb begin
        win = '0;
        for (int j = 0; j < K; j++) begin
            for (int i = 0; i < K; i++) begin
                win[(j*K+i)*DW +: DW] = r_win[j][i];
            end
        end
    end

    assign win_vld = r_win_vld;
    assign win_sof = r_win_sof;
    assign win_eol = r_win_eol;

endmodule

// File: tb/tb_matrix_kxk_win.sv
// Directed bench for matrix_kxk_win: 3x3 window over a 4x3 frame of pixels 1..12,
// with one replicate-border and one zero-border instance sharing the stimulus.
module tb_matrix_kxk_win;
   import matrix_kxk_win_pkg::*;

   localparam int WW = 72;

   typedef struct packed {
      logic [WW-1:0] win;
      logic          sof;
      logic          eol;
   } capT;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          din_vld;
   logic          din_sof;
   logic [7:0]    din;
   logic [WW-1:0] win0, win1;
   logic          winVld0, winSof0, winEol0;
   logic          winVld1, winSof1, winEol1;

   int  checks = 0;
   int  errors = 0;
   capT q0[$];
   capT q1[$];
   bit  stableEn = 1'b0;
   int  unstable = 0;
   logic [WW-1:0] prev0 = '0;
   logic [WW-1:0] prev1 = '0;

   always #5 clk = ~clk;

   matrix_kxk_win #(
      .DW(8), .K(3), .H_DISP(4), .V_DISP(3), .BORDER(BORDER_REPL)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_sof(din_sof), .din(din),
      .win(win0), .win_vld(winVld0), .win_sof(winSof0), .win_eol(winEol0)
   );

   matrix_kxk_win #(
      .DW(8), .K(3), .H_DISP(4), .V_DISP(3), .BORDER(BORDER_ZERO)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_sof(din_sof), .din(din),
      .win(win1), .win_vld(winVld1), .win_sof(winSof1), .win_eol(winEol1)
   );

   // Record every valid window shortly after the clock edge, and watch for
   // the window moving while it is not flagged valid.
   always @(posedge clk) begin
      #1;
      if (winVld0) q0.push_back({win0, winSof0, winEol0});
      if (winVld1) q1.push_back({win1, winSof1, winEol1});
      if (stableEn && !winVld0 && (win0 !== prev0)) unstable++;
      if (stableEn && !winVld1 && (win1 !== prev1)) unstable++;
      prev0 = win0;
      prev1 = win1;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [WW-1:0] mkWin(input int e00, input int e01, input int e02,
                                           input int e10, input int e11, input int e12,
                                           input int e20, input int e21, input int e22);
      int e[9];
      logic [WW-1:0] w;
      e = '{e00, e01, e02, e10, e11, e12, e20, e21, e22};
      w = '0;
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(e[k]);
      return w;
   endfunction

   // Reference window for frame pixel value r*4+c+1 at (r,c).
   function automatic logic [WW-1:0] modelWin(input int r, input int c, input bit zero);
      logic [WW-1:0] w;
      int rr, cc, v;
      w = '0;
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 3; i++) begin
            rr = r - 2 + j;
            cc = c - 2 + i;
            if (zero && (rr < 0 || cc < 0)) begin
               v = 0;
            end else begin
               if (rr < 0) rr = 0;
               if (cc < 0) cc = 0;
               v = rr * 4 + cc + 1;
            end
            w[(j*3+i)*8 +: 8] = 8'(v);
         end
      end
      return w;
   endfunction

   function automatic capT getCap(input capT q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return '0;
   endfunction

   task automatic applyStimulus(input logic vld, input logic sof, input logic [7:0] val);
      @(negedge clk);
      din_vld = vld;
      din_sof = sof;
      din     = val;
   endtask

   task automatic checkOutput(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // One frame of pixels 1..12; gaps carry din_sof=1 and junk data, which must be ignored.
   task automatic sendFrame(input bit withSof, input int maxGap);
      int g;
      for (int p = 1; p <= 12; p++) begin
         applyStimulus(1'b1, withSof && (p == 1), 8'(p));
         g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
         if (maxGap > 0 && (p % 4) == 0 && g < 2) g = 2;
         for (int k = 0; k < g; k++) applyStimulus(1'b0, 1'b1, 8'hEE);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic checkFrame(input string tag, input capT q[$], input bit zero);
      capT e;
      checkOutput({tag, " count"}, WW'(q.size()), WW'(12));
      for (int idx = 0; idx < 12; idx++) begin
         e = getCap(q, idx);
         checkOutput($sformatf("%s win %0d", tag, idx), e.win, modelWin(idx / 4, idx % 4, zero));
         checkOutput($sformatf("%s sof %0d", tag, idx), WW'(e.sof), WW'(idx == 0));
         checkOutput($sformatf("%s eol %0d", tag, idx), WW'(e.eol), WW'((idx % 4) == 3));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      din_vld = 1'b0;
      din_sof = 1'b0;
      din     = '0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset win0", win0, '0);
      checkOutput("reset win1", win1, '0);
      checkOutput("reset flags0", WW'({winVld0, winSof0, winEol0}), '0);
      checkOutput("reset flags1", WW'({winVld1, winSof1, winEol1}), '0);
      applyStimulus(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;

      // First pixel and its two-cycle latency
      applyStimulus(1'b1, 1'b1, 8'd1);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("latency vld +1", WW'(winVld0), WW'(0));
      applyStimulus(1'b1, 1'b0, 8'd2);
      checkOutput("latency vld +2", WW'(winVld0), WW'(1));
      checkOutput("first pixel win", win0, mkWin(1, 1, 1, 1, 1, 1, 1, 1, 1));
      checkOutput("first pixel sof", WW'(winSof0), WW'(1));
      for (int p = 3; p <= 12; p++) applyStimulus(1'b1, 1'b0, 8'(p));
      repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);

      // Row 1 / column 1 border and interior windows
      checkOutput("pixel6 replicate", getCap(q0, 5).win, mkWin(1, 1, 2, 1, 1, 2, 5, 5, 6));
      checkOutput("pixel6 zero", getCap(q1, 5).win, mkWin(0, 0, 0, 0, 1, 2, 0, 5, 6));
      checkOutput("pixel12 interior", getCap(q0, 11).win, mkWin(2, 3, 4, 6, 7, 8, 10, 11, 12));
      checkOutput("pixel12 eol", WW'(getCap(q0, 11).eol), WW'(1));
      checkFrame("frame1 repl", q0, 1'b0);
      checkFrame("frame1 zero", q1, 1'b1);

      // Random gaps, forced gaps at line ends, sof toggling while idle
      q0.delete();
      q1.delete();
      stableEn = 1'b1;
      sendFrame(1'b1, 5);
      stableEn = 1'b0;
      checkOutput("gap stability", WW'(unstable), WW'(0));
      checkFrame("gap repl", q0, 1'b0);
      checkFrame("gap zero", q1, 1'b1);

      // Mid-frame resync on pixel 7
      q0.delete();
      q1.delete();
      for (int p = 1; p <= 6; p++) applyStimulus(1'b1, p == 1, 8'(p));
      applyStimulus(1'b1, 1'b1, 8'd7);
      applyStimulus(1'b1, 1'b0, 8'd8);
      repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("resync count", WW'(q0.size()), WW'(8));
      checkOutput("resync win7 repl", getCap(q0, 6).win, mkWin(7, 7, 7, 7, 7, 7, 7, 7, 7));
      checkOutput("resync sof7", WW'(getCap(q0, 6).sof), WW'(1));
      checkOutput("resync win8 repl", getCap(q0, 7).win, mkWin(7, 7, 8, 7, 7, 8, 7, 7, 8));
      checkOutput("resync sof8", WW'(getCap(q0, 7).sof), WW'(0));
      checkOutput("resync win7 zero", getCap(q1, 6).win, mkWin(0, 0, 0, 0, 0, 0, 0, 0, 7));
      checkOutput("resync win8 zero", getCap(q1, 7).win, mkWin(0, 0, 0, 0, 0, 0, 0, 7, 8));

      // Reset in the middle of a frame
      for (int p = 1; p <= 5; p++) applyStimulus(1'b1, p == 1, 8'(p));
      @(negedge clk);
      din_vld = 1'b1;
      din_sof = 1'b0;
      din     = 8'd6;
      rst_n   = 1'b0;
      q0.delete();
      q1.delete();
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput($sformatf("in reset win0 %0d", k), win0, '0);
         checkOutput($sformatf("in reset flags0 %0d", k), WW'({winVld0, winSof0, winEol0}), '0);
         checkOutput($sformatf("in reset win1 %0d", k), win1, '0);
      end
      rst_n = 1'b1;
      repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("no stray vld", WW'(q0.size() + q1.size()), WW'(0));
      sendFrame(1'b0, 0);
      checkOutput("restart first win", getCap(q0, 0).win, mkWin(1, 1, 1, 1, 1, 1, 1, 1, 1));
      checkOutput("restart first sof", WW'(getCap(q0, 0).sof), WW'(1));
      checkOutput("restart interior", getCap(q0, 11).win, mkWin(2, 3, 4, 6, 7, 8, 10, 11, 12));
      checkFrame("restart repl", q0, 1'b0);
      checkFrame("restart zero", q1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
